// File: rtl/bp_btb_pht_param_if.sv
// Fetch/train bus between the core (master) and the branch predictor (slave).
// The lookup request and the resolved-branch update travel towards the predictor;
// the registered prediction travels back towards the fetch stage.
interface bp_btb_pht_param_if #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 6
);
    // Lookup request from IF
    logic [PC_W-1:0]  pc_i;
    logic             if_allowin_i;

    // Registered prediction, aligned with the instruction fetch data
    logic             pred_hit_o;
    logic             pred_taken_o;
    logic [PC_W-1:0]  pred_target_o;
    logic [IDX_W-1:0] pred_idx_o;

    // Training port from IS
    logic             upd_valid_i;
    logic [PC_W-1:0]  upd_pc_i;
    logic [IDX_W-1:0] upd_idx_i;
    logic             upd_taken_i;
    logic [PC_W-1:0]  upd_target_i;

    modport master (
        output pc_i, if_allowin_i,
        output upd_valid_i, upd_pc_i, upd_idx_i, upd_taken_i, upd_target_i,
        input  pred_hit_o, pred_taken_o, pred_target_o, pred_idx_o
    );

    modport slave (
        input  pc_i, if_allowin_i,
        input  upd_valid_i, upd_pc_i, upd_idx_i, upd_taken_i, upd_target_i,
        output pred_hit_o, pred_taken_o, pred_target_o, pred_idx_o
    );
endinterface

// File: rtl/bp_btb_pht_param.sv
// Parametrised branch predictor: direct-mapped, tagged BTB with a 2-bit
// saturating counter per entry. Index is either PC bits (bimodal) or PC bits
// xor a non-speculative global history register (gshare). The prediction is
// registered, so it appears one cycle after the PC is presented. Lookups read
// the pre-update contents when a lookup and an update hit the same entry.
module bp_btb_pht_param #(
    parameter int PC_W    = 32,
    parameter int ENTRIES = 64,   // power of two, 4..1024
    parameter int TAG_W   = 8,
    parameter int GSHARE  = 0,    // 0 = bimodal index, 1 = gshare index
    parameter int GHR_W   = 6     // 1..IDX_W, only used when GSHARE=1
) (
    input  logic               clk,
    input  logic               resetn,
    bp_btb_pht_param_if.slave  bus
);

    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int IDX_LO  = 2;
    localparam int TAG_LO  = IDX_W + 2;
    localparam int TAG_TOP = TAG_W + IDX_W + 2;   // first PC bit not covered by tag/index

    // ------------------------------------------------------------------
    // Index and tag extraction
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_ghr_ext;
    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [TAG_W-1:0] w_upd_tag;

    assign w_lk_idx  = bus.pc_i[IDX_W+1:IDX_LO] ^ w_ghr_ext;
    assign w_lk_tag  = bus.pc_i[TAG_TOP-1:TAG_LO];
    assign w_upd_tag = bus.upd_pc_i[TAG_TOP-1:TAG_LO];

    // ------------------------------------------------------------------
    // Entry storage, flattened so the read muxes can index it
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0]            w_valid_vec;
    logic [ENTRIES-1:0][TAG_W-1:0] w_tag_arr;
    logic [ENTRIES-1:0][PC_W-1:0]  w_tgt_arr;
    logic [ENTRIES-1:0][1:0]       w_ctr_arr;

    // Update-side hit is evaluated once on the carried index, never recomputed
    logic w_upd_hit;
    assign w_upd_hit = w_valid_vec[bus.upd_idx_i] &&
                       (w_tag_arr[bus.upd_idx_i] == w_upd_tag);

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             r_valid;
            logic [TAG_W-1:0] r_tag;
            logic [PC_W-1:0]  r_target;
            logic [1:0]       r_ctr;
            logic             w_sel;

            assign w_sel = bus.upd_valid_i && (bus.upd_idx_i == IDX_W'(gi));

            // Train this entry: strengthen/retarget on taken hit, allocate on
            // taken miss, weaken on not-taken hit, ignore not-taken miss
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_valid  <= 1'b0;
                    r_tag    <= '0;
                    r_target <= '0;
                    r_ctr    <= 2'b01;
                end else if (w_sel) begin
                    if (bus.upd_taken_i && w_upd_hit) begin
                        if (r_ctr != 2'b11) begin
                            r_ctr <= r_ctr + 2'b01;
                        end
                        r_target <= bus.upd_target_i;
                    end else if (bus.upd_taken_i) begin
                        r_valid  <= 1'b1;
                        r_tag    <= w_upd_tag;
                        r_target <= bus.upd_target_i;
                        r_ctr    <= 2'b10;
                    end else if (w_upd_hit) begin
                        if (r_ctr != 2'b00) begin
                            r_ctr <= r_ctr - 2'b01;
                        end
                    end
                end
            end

            assign w_valid_vec[gi] = r_valid;
            assign w_tag_arr[gi]   = r_tag;
            assign w_tgt_arr[gi]   = r_target;
            assign w_ctr_arr[gi]   = r_ctr;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Global history (gshare only); trained only by resolved branches
    // ------------------------------------------------------------------
    generate
        if (GSHARE != 0) begin : g_gshare
            logic [GHR_W-1:0] r_ghr;

            if (GHR_W == 1) begin : g_ghr1
                // Single-bit history just remembers the last outcome
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) begin
                        r_ghr <= '0;
                    end else if (bus.upd_valid_i) begin
                        r_ghr <= bus.upd_taken_i;
                    end
                end
            end else begin : g_ghrn
                // Shift the newest outcome into the LSB
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) begin
                        r_ghr <= '0;
                    end else if (bus.upd_valid_i) begin
                        r_ghr <= {r_ghr[GHR_W-2:0], bus.upd_taken_i};
                    end
                end
            end

            assign w_ghr_ext = IDX_W'(r_ghr);
        end else begin : g_bimodal
            assign w_ghr_ext = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Lookup read and registered prediction
    // ------------------------------------------------------------------
    logic             w_rd_hit;
    logic [PC_W-1:0]  w_rd_target;
    logic [1:0]       w_rd_ctr;

    assign w_rd_hit    = w_valid_vec[w_lk_idx] && (w_tag_arr[w_lk_idx] == w_lk_tag);
    assign w_rd_target = w_tgt_arr[w_lk_idx];
    assign w_rd_ctr    = w_ctr_arr[w_lk_idx];

    logic             r_hit;
    logic             r_taken;
    logic [PC_W-1:0]  r_target;
    logic [IDX_W-1:0] r_idx;

    // Capture the prediction when IF accepts the PC; hold it while IF stalls
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hit    <= 1'b0;
            r_taken  <= 1'b0;
            r_target <= '0;
            r_idx    <= '0;
        end else if (bus.if_allowin_i) begin
            r_hit    <= w_rd_hit;
            r_taken  <= w_rd_hit && w_rd_ctr[1];
            r_target <= w_rd_hit ? w_rd_target : '0;
            r_idx    <= w_lk_idx;
        end
    end

    assign bus.pred_hit_o    = r_hit;
    assign bus.pred_taken_o  = r_taken;
    assign bus.pred_target_o = r_target;
    assign bus.pred_idx_o    = r_idx;

    // ------------------------------------------------------------------
    // PC bits outside tag+index are deliberately ignored (aliasing allowed)
    // ------------------------------------------------------------------
    logic w_unused_hi;
    generate
        if (PC_W > TAG_TOP) begin : g_pc_hi
            assign w_unused_hi = ^{bus.pc_i[PC_W-1:TAG_TOP], bus.upd_pc_i[PC_W-1:TAG_TOP]};
        end else begin : g_pc_nohi
            assign w_unused_hi = 1'b0;
        end
    endgenerate

    logic w_unused_bits;
    assign w_unused_bits = ^{w_unused_hi, bus.pc_i[1:0], bus.upd_pc_i[1:0]};

endmodule
